dili_ntt_ctrl: RTL and testbench

Sequencer that runs a full 256-point Dilithium NTT or INTT (q = 8380417) on one shared pipelined butterfly unit and one dual-port coefficient RAM, in place of the fully unrolled combinational transform.

---
 rtl/dili_pkg.sv | 48 ++++
 rtl/dili_pipe_delay.sv | 49 ++++
 rtl/dili_ntt_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dili_ntt_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dili_pkg.sv
// Shared types and constants for the Dilithium NTT sequencer.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package dili_pkg;

    localparam int DILI_N      = 256;
    localparam int DILI_Q      = 8380417;
    localparam int DILI_NINV   = 8347681;
    localparam int DILI_ADDR_W = 8;

    typedef enum logic [1:0] {
        BF_CT    = 2'b00,
        BF_GS    = 2'b01,
        BF_SCALE = 2'b10
    } bf_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAYER,
        ST_DRAIN,
        ST_SCALE,
        ST_SDRAIN,
        ST_DONE
    } ntt_state_t;

    // First operand address: butterfly counter with a zero inserted at bit p.
    function automatic logic [7:0] bf_addr_a(input logic [6:0] b, input logic [2:0] p);
        logic [7:0] bw;
        logic [7:0] lo_mask;
        bw      = {1'b0, b};
        lo_mask = (8'd1 << p) - 8'd1;
        return ((bw & ~lo_mask) << 1) | (bw & lo_mask);
    endfunction

    // Zeta ROM index: ascending 1..255 forward, descending 255..1 inverse.
    function automatic logic [7:0] bf_zeta(input logic [6:0] b, input logic [2:0] layer,
                                           input logic inv);
        logic [2:0] p;
        logic [6:0] g;
        logic [8:0] z;
        p = inv ? layer : 3'd7 - layer;
        g = b >> p;
        if (inv) z = (9'd256 >> layer) - 9'd1 - {2'b00, g};
        else     z = (9'd1 << layer) + {2'b00, g};
        return z[7:0];
    endfunction

endpackage

// File: rtl/dili_pipe_delay.sv
// Delay line carrying {valid, addr_a, addr_b} from RAM read issue to write-back.
// Latency: exactly LAT cycles.
// Backpressure: none; shifts every cycle, synchronous clear drops in-flight writes.
module dili_pipe_delay
    import dili_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   vld_i,
    input  logic [DILI_ADDR_W-1:0] addr_a_i,
    input  logic [DILI_ADDR_W-1:0] addr_b_i,
    output logic                   vld_o,
    output logic [DILI_ADDR_W-1:0] addr_a_o,
    output logic [DILI_ADDR_W-1:0] addr_b_o
);

    typedef struct packed {
        logic                   vld;
        logic [DILI_ADDR_W-1:0] a;
        logic [DILI_ADDR_W-1:0] b;
    } slot_t;

    slot_t pipe_q [LAT];
    slot_t pipe_d [LAT];

    // Shift: new issue enters slot 0, everything else moves one slot along.
    always_comb begin
        pipe_d[0] = '{vld: vld_i, a: addr_a_i, b: addr_b_i};
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Slot registers; reset empties the line so no stale write escapes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign vld_o    = pipe_q[LAT-1].vld;
    assign addr_a_o = pipe_q[LAT-1].a;
    assign addr_b_o = pipe_q[LAT-1].b;

endmodule

// File: rtl/dili_ntt_ctrl.sv
// Sequences a 256-point Dilithium NTT/INTT onto one butterfly unit, one butterfly per cycle.
// Latency: forward done 1+8*(128+LAT) cycles after start; inverse adds a 128-issue scale pass.
// Backpressure: none; the butterfly unit and RAM must accept one issue per cycle.
module dili_ntt_ctrl
    import dili_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       mode_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [7:0] zeta_idx_o,
    output logic [1:0] bf_op_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o,
    output logic [3:0] layer_o
);

    localparam int         ADDR_W = DILI_ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
    localparam logic [6:0] B_LAST = 7'(DILI_N / 2 - 1);

    ntt_state_t        state_q, state_d;
    logic              mode_q, mode_d;
    logic [3:0]        layer_q, layer_d;
    logic [6:0]        b_q, b_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [7:0]        zeta_q, zeta_d;
    bf_op_t            op_q, op_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        p_sel;

    // Next state, then the issue registers are loaded from the next state so
    // that the outputs in a cycle describe the butterfly of that cycle's state.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        layer_d  = layer_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        zeta_d   = zeta_q;
        op_d     = op_q;
        p_sel    = 3'd0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    mode_d  = mode_i;
                    layer_d = 4'd0;
                    b_d     = 7'd0;
                    state_d = ST_LAYER;
                end
            end
            ST_LAYER: begin
                if (b_q == B_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DRAIN;
                end else begin
                    b_d = b_q + 7'd1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == LAT_M1) begin
                    b_d = 7'd0;
                    if (layer_q != 4'd7) begin
                        layer_d = layer_q + 4'd1;
                        state_d = ST_LAYER;
                    end else if (mode_q) begin
                        layer_d = 4'd8;
                        state_d = ST_SCALE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SCALE: begin
                if (b_q == B_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_SDRAIN;
                end else begin
                    b_d = b_q + 7'd1;
                end
            end
            ST_SDRAIN: begin
                if (cnt_q == LAT_M1) state_d = ST_DONE;
                else                 cnt_d   = cnt_q + 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Address/op registers only move on an issue; otherwise they hold.
        if (state_d == ST_LAYER) begin
            p_sel    = mode_d ? layer_d[2:0] : 3'd7 - layer_d[2:0];
            addr_a_d = bf_addr_a(b_d, p_sel);
            addr_b_d = addr_a_d | (8'd1 << p_sel);
            zeta_d   = bf_zeta(b_d, layer_d[2:0], mode_d);
            op_d     = mode_d ? BF_GS : BF_CT;
        end else if (state_d == ST_SCALE) begin
            addr_a_d = bf_addr_a(b_d, 3'd0);
            addr_b_d = addr_a_d | 8'd1;
            zeta_d   = 8'd0;
            op_d     = BF_SCALE;
        end

        rd_en_d = (state_d == ST_LAYER) || (state_d == ST_SCALE);
        busy_d  = rd_en_d || (state_d == ST_DRAIN) || (state_d == ST_SDRAIN);
        done_d  = (state_d == ST_DONE);
    end

    // State and registered outputs, all cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            layer_q  <= 4'd0;
            b_q      <= 7'd0;
            cnt_q    <= 4'd0;
            rd_en_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            zeta_q   <= 8'd0;
            op_q     <= BF_CT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            layer_q  <= layer_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            rd_en_q  <= rd_en_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            zeta_q   <= zeta_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    dili_pipe_delay #(.LAT(LAT)) u_dly (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .vld_i    (rd_en_q),
        .addr_a_i (addr_a_q),
        .addr_b_i (addr_b_q),
        .vld_o    (wr_en_o),
        .addr_a_o (wr_addr_a_o),
        .addr_b_o (wr_addr_b_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_a_o = addr_a_q;
    assign rd_addr_b_o = addr_b_q;
    assign zeta_idx_o  = zeta_q;
    assign bf_op_o     = op_q;
    assign layer_o     = layer_q;

endmodule

// File: tb/tb_dili_ntt_ctrl.sv
// Bench for dili_ntt_ctrl: LAT=4 checked against a reference-loop issue model,
// LAT=1 and LAT=7 instances checked for exact write delay and layer ordering.
// All three share start/mode/reset.
module tb_dili_ntt_ctrl;

    logic clk = 1'b0;
    logic rst, start, mode;
    int   cyc = 0;
    int   t0 = 0;
    int   checks = 0;
    int   errors = 0;

    logic       busy [3], done [3], rd_en [3], wr_en [3];
    logic [7:0] rd_a [3], rd_b [3], zeta [3], wr_a [3], wr_b [3];
    logic [1:0] op [3];
    logic [3:0] layer [3];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z;
        logic [1:0] op;
        logic [3:0] lyr;
    } exp_iss_t;

    typedef struct {
        int dut;
        int a;
        int b;
        int due;
    } wr_exp_t;

    typedef struct {
        logic mode;
        logic poke;
        int   exp_done;
        int   exp_pulses;
    } vec_t;

    exp_iss_t   iq [$];
    wr_exp_t    pq [$];
    vec_t       tbl [3];
    int         rd_cnt [3], wr_cnt [3], done_cnt [3], done_rel [3], first_rel [3];
    bit         have_last [3];
    logic [3:0] last_layer [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dili_ntt_ctrl #(.LAT(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .busy_o(busy[0]), .done_o(done[0]), .rd_en_o(rd_en[0]),
        .rd_addr_a_o(rd_a[0]), .rd_addr_b_o(rd_b[0]), .zeta_idx_o(zeta[0]),
        .bf_op_o(op[0]), .wr_en_o(wr_en[0]), .wr_addr_a_o(wr_a[0]),
        .wr_addr_b_o(wr_b[0]), .layer_o(layer[0])
    );

    dili_ntt_ctrl #(.LAT(1)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .busy_o(busy[1]), .done_o(done[1]), .rd_en_o(rd_en[1]),
        .rd_addr_a_o(rd_a[1]), .rd_addr_b_o(rd_b[1]), .zeta_idx_o(zeta[1]),
        .bf_op_o(op[1]), .wr_en_o(wr_en[1]), .wr_addr_a_o(wr_a[1]),
        .wr_addr_b_o(wr_b[1]), .layer_o(layer[1])
    );

    dili_ntt_ctrl #(.LAT(7)) u_dut_l7 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .busy_o(busy[2]), .done_o(done[2]), .rd_en_o(rd_en[2]),
        .rd_addr_a_o(rd_a[2]), .rd_addr_b_o(rd_b[2]), .zeta_idx_o(zeta[2]),
        .bf_op_o(op[2]), .wr_en_o(wr_en[2]), .wr_addr_a_o(wr_a[2]),
        .wr_addr_b_o(wr_b[2]), .layer_o(layer[2])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 7);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc - t0);
        end
    endtask

    function automatic exp_iss_t mk(input int a, input int b, input int z, input int o,
                                    input int l);
        exp_iss_t e;
        e.a   = 8'(a);
        e.b   = 8'(b);
        e.z   = 8'(z);
        e.op  = 2'(o);
        e.lyr = 4'(l);
        return e;
    endfunction

    // Reference Cooley-Tukey loop nest: zeta index advances once per group.
    task automatic push_fwd();
        int k;
        int lyr;
        k   = 0;
        lyr = 0;
        for (int len = 128; len >= 1; len = len / 2) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                k++;
                for (int j = st; j < st + len; j++) iq.push_back(mk(j, j + len, k, 0, lyr));
            end
            lyr++;
        end
    endtask

    // Reference Gentleman-Sande loop nest, then the n^-1 scale pass.
    task automatic push_inv();
        int k;
        int lyr;
        k   = 256;
        lyr = 0;
        for (int len = 1; len <= 128; len = len * 2) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                k--;
                for (int j = st; j < st + len; j++) iq.push_back(mk(j, j + len, k, 1, lyr));
            end
            lyr++;
        end
        for (int i = 0; i < 128; i++) iq.push_back(mk(2 * i, 2 * i + 1, 0, 2, 8));
    endtask

    // Scoreboard: every issue predicts a write LAT cycles later.
    always @(negedge clk) begin : mon
        int       idx;
        int       pend;
        exp_iss_t e;
        exp_iss_t act;
        for (int d = 0; d < 3; d++) begin
            idx = -1;
            for (int i = 0; i < pq.size(); i++) if (idx < 0 && pq[i].dut == d) idx = i;
            if (wr_en[d]) begin
                wr_cnt[d]++;
                if (idx < 0) begin
                    chk($sformatf("wr_unexpected_d%0d", d), longint'(wr_en[d]), 0);
                end else begin
                    chk($sformatf("wr_addr_d%0d", d), longint'({wr_a[d], wr_b[d]}),
                        longint'(pq[idx].a * 256 + pq[idx].b));
                    chk($sformatf("wr_time_d%0d", d), longint'(cyc), longint'(pq[idx].due));
                    pq.delete(idx);
                end
            end else if (idx >= 0 && pq[idx].due <= cyc) begin
                chk($sformatf("wr_missing_d%0d", d), longint'(wr_en[d]), 1);
                pq.delete(idx);
            end
            if (rd_en[d]) begin
                if (have_last[d] && layer[d] != last_layer[d]) begin
                    pend = 0;
                    for (int i = 0; i < pq.size(); i++) if (pq[i].dut == d) pend++;
                    chk($sformatf("layer_order_d%0d", d), longint'(pend), 0);
                end
                have_last[d]  = 1'b1;
                last_layer[d] = layer[d];
                if (rd_cnt[d] == 0) first_rel[d] = cyc - t0;
                rd_cnt[d]++;
                pq.push_back('{d, int'(rd_a[d]), int'(rd_b[d]), cyc + lat_of(d)});
                if (d == 0) begin
                    act = {rd_a[0], rd_b[0], zeta[0], op[0], layer[0]};
                    if (iq.size() == 0) begin
                        chk("issue_extra", longint'(rd_en[0]), 0);
                    end else begin
                        e = iq.pop_front();
                        chk("issue", longint'(act), longint'(e));
                    end
                end
            end
            if (done[d]) begin
                done_cnt[d]++;
                done_rel[d] = cyc - t0;
            end
        end
        if (rst) begin
            pq.delete();
            iq.delete();
            for (int d = 0; d < 3; d++) have_last[d] = 1'b0;
        end
    end

    task automatic clr_counts();
        for (int d = 0; d < 3; d++) begin
            rd_cnt[d]    = 0;
            wr_cnt[d]    = 0;
            done_cnt[d]  = 0;
            done_rel[d]  = -1;
            first_rel[d] = -1;
        end
    endtask

    task automatic wait_rel(input int n);
        while (cyc - t0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && (busy[0] || busy[1] || busy[2]); k++) begin
            @(posedge clk);
            #1;
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic run(input logic m, input logic poke, input int exp_done, input int exp_pulses);
        int rel;
        if (m) push_inv();
        else   push_fwd();
        @(posedge clk);
        #1;
        clr_counts();
        t0    = cyc;
        start = 1'b1;
        mode  = m;
        for (int k = 0; k < 3000 && done_cnt[0] == 0; k++) begin
            @(posedge clk);
            #1;
            rel   = cyc - t0;
            start = poke && (rel == 10 || rel == 500);
            mode  = (poke && (rel == 10 || rel == 500)) ? ~m : m;
        end
        start = 1'b0;
        mode  = m;
        wait_idle();
        chk("first_rd_cycle", longint'(first_rel[0]), 1);
        chk("done_cycle", longint'(done_rel[0]), longint'(exp_done));
        chk("done_count", longint'(done_cnt[0]), 1);
        chk("rd_pulses", longint'(rd_cnt[0]), longint'(exp_pulses));
        chk("wr_pulses", longint'(wr_cnt[0]), longint'(exp_pulses));
        chk("model_left", longint'(iq.size()), 0);
        chk("lat1_pulses", longint'(wr_cnt[1]), longint'(exp_pulses));
        chk("lat7_pulses", longint'(wr_cnt[2]), longint'(exp_pulses));
        if (!m) begin
            chk("lat1_done", longint'(done_rel[1]), longint'(1 + 8 * (128 + 1)));
            chk("lat7_done", longint'(done_rel[2]), longint'(1 + 8 * (128 + 7)));
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1057, 1024};
        tbl[1] = '{1'b1, 1'b0, 1189, 1152};
        tbl[2] = '{1'b0, 1'b1, 1057, 1024};

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        clr_counts();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", longint'({busy[0], done[0], rd_en[0], rd_a[0], rd_b[0], zeta[0],
                                       op[0], wr_en[0], wr_a[0], wr_b[0], layer[0]}), 0);
        chk("reset_aux", longint'({busy[1], rd_en[1], wr_en[1], busy[2], rd_en[2], wr_en[2]}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 3; v++) run(tbl[v].mode, tbl[v].poke, tbl[v].exp_done, tbl[v].exp_pulses);

        // Reset in the middle of layer 2, then a clean forward pass.
        push_fwd();
        @(posedge clk);
        #1;
        clr_counts();
        t0    = cyc;
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_rel(300);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", longint'({busy[0], done[0], rd_en[0], rd_a[0], rd_b[0], zeta[0],
                                          op[0], wr_en[0], wr_a[0], wr_b[0], layer[0]}), 0);
        clr_counts();
        repeat (30) @(posedge clk);
        #1;
        chk("midreset_no_wr", longint'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2]), 0);
        run(1'b0, 1'b0, 1057, 1024);

        // Back-to-back: inverse, then forward started in the DONE cycle.
        push_inv();
        push_fwd();
        @(posedge clk);
        #1;
        clr_counts();
        t0    = cyc;
        start = 1'b1;
        mode  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_rel(1189);
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        chk("b2b_done_pulse", longint'({done[0], busy[0]}), 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 1'b1;
        @(negedge clk);
        chk("b2b_first_issue", longint'({rd_en[0], rd_a[0], rd_b[0], zeta[0], op[0], layer[0]}),
            longint'({1'b1, 8'd0, 8'd128, 8'd1, 2'b00, 4'd0}));
        for (int k = 0; k < 1500 && done_cnt[0] < 2; k++) begin
            @(posedge clk);
            #1;
        end
        wait_idle();
        chk("b2b_done_count", longint'(done_cnt[0]), 2);
        chk("b2b_done_cycle", longint'(done_rel[0]), 1189 + 1057);
        chk("b2b_rd_pulses", longint'(rd_cnt[0]), 1152 + 1024);
        chk("b2b_wr_pulses", longint'(wr_cnt[0]), 1152 + 1024);
        chk("b2b_model_left", longint'(iq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
